// File: rtl/im_loader.sv
// Run-time instruction-memory loader: takes a length-prefixed byte stream and
// writes big-endian 32-bit words into the instruction store while holding the CPU.
module im_loader #(
  parameter int unsigned BASE_WORD = 3072,
  parameter int unsigned MAX_WORDS = 13312
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        we,
  output logic [13:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [13:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] hdr_n;
  logic        xfer;

  // Outputs are pure decodes of registered state, so they stay Moore/glitch-free.
  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign we         = (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign cpu_hold   = (state_q != S_DONE);
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;

  assign xfer  = byte_valid && byte_ready;
  assign hdr_n = {len_q[15:8], byte_in};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_in;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = hdr_n;
          if (hdr_n == '0) begin
            state_d = S_DONE;
          end else if (hdr_n > 16'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            waddr_d = 14'(BASE_WORD);
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wdata_d = {wdata_q[23:0], byte_in};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        waddr_d = waddr_q + 14'd1;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = '0;
        state_d = (cnt_q + 16'd1 == len_q) ? S_DONE : S_DATA;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      waddr_q <= 14'(BASE_WORD);
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: doc/im_loader.md
# im_loader

Run-time writer for the instruction memory. It accepts a byte stream from a host link, assembles big-endian 32-bit instruction words, and issues one-cycle write strobes into the instruction store starting at word index 3072 (byte address 0x3000). It holds the CPU stalled while loading and releases it when the programmed word count has been written. Loading at run time replaces the simulation-only file preload.

## Interface
Parameters:
- BASE_WORD, 3072: word index (addr[15:2]) of the first written instruction.
- MAX_WORDS, 13312: largest legal word count (BASE_WORD..16383).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader can accept a byte; a transfer occurs when byte_valid && byte_ready.
- we  out  1  instruction-memory write strobe, one cycle per word.
- waddr  out  14  word address [15:2] for the write.
- wdata  out  32  assembled instruction word.
- cpu_hold  out  1  keep CPU stalled or in reset while high.
- done  out  1  load completed successfully.
- err  out  1  header word count exceeded MAX_WORDS.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- IDLE: byte_ready=0, cpu_hold=1. A start pulse moves to LEN_HI.
- LEN_HI / LEN_LO: byte_ready=1. Accept 2 header bytes, MSB first, into a 16-bit count N.
  - After the LEN_LO byte is accepted: N==0 goes to DONE; N>MAX_WORDS goes to ERR; otherwise the state goes to DATA with waddr=BASE_WORD, byte index 0, and word counter 0.
- DATA: byte_ready=1. Accepted bytes shift into wdata MSB-first: byte 0 lands in [31:24] and byte 3 in [7:0]. Accepting byte 3 moves to WRITE.
- WRITE: byte_ready=0 and we=1 for exactly this cycle, with waddr and wdata stable.
  - Next edge: waddr increments, the word counter increments, and the byte index clears.
  - If the counter reaches N, go to DONE; otherwise return to DATA.
- DONE: done=1, cpu_hold=0, byte_ready=0. A start pulse clears done, sets cpu_hold=1, and goes to LEN_HI (reload).
- ERR: err=1, cpu_hold=1, byte_ready=0, with no writes. The state is left only by rst; start is ignored.
- Bytes presented while byte_ready=0 are not consumed and cause no state change.
- start outside IDLE/DONE is ignored.
- waddr arithmetic is 14-bit. With a legal N, the last address is BASE_WORD+N-1 ≤ 16383, so no wrap occurs.

## Timing
- Reset values: state=IDLE, byte_ready=0, we=0, waddr=BASE_WORD, wdata=0, cpu_hold=1, done=0, err=0. Internal count, counter, and byte index are 0.
- rst mid-load aborts immediately. No further we is issued, and any partial word is discarded.
- All outputs are registered (Moore).
- byte_ready rises in the cycle after start is sampled.
- we is high in the cycle after the 4th data byte is accepted.
- Peak throughput: 4 bytes plus 1 write cycle = 5 cycles per word.
- done rises in the cycle after the final WRITE cycle, or in the cycle after the LEN_LO byte when N=0.
- err rises in the cycle after the LEN_LO byte. cpu_hold falls in the same cycle done rises.
- Back-to-back valid bytes are accepted every cycle in LEN/DATA. Gaps in byte_valid simply stall the FSM.

## Test plan
- Reset, then idle for 10 cycles: outputs stay at reset values; cpu_hold=1 and waddr=3072.
- start, then bytes 00 02 | 24 01 00 05 | 00 00 00 0C at full rate:
  - we at waddr 3072 with wdata 0x24010005, then at 3073 with 0x0000000C, exactly 2 strobes.
  - done=1 and cpu_hold=0 one cycle after the second write.
- Same stream with byte_valid toggled every other cycle: identical writes and data; only the timing stretches.
- Header 00 00: no we; done=1 the cycle after the second header byte.
- Header 34 01 (13313 > MAX_WORDS): err=1, no we, byte_ready=0; start ignored until rst.
- rst asserted after 2 data bytes of word 0: no we issued. A following start with header 00 01 and bytes AA BB CC DD writes 0xAABBCCDD at 3072.
